// File: rtl/rv_mem_req_tagger.sv
// Memory request tagger: allocates the lowest free tag per LSU request, stores its metadata,
// and rejoins that metadata with out-of-order responses. Optional macro: RV_TAGGER_CHECK_EN.
module rv_mem_req_tagger #(
    parameter int DATAW  = 8,
    parameter int ADDRW  = 32,
    parameter int RDATAW = 32,
    parameter int SIZE   = 4,
    parameter int TAGW   = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDRW-1:0]  req_addr,
    input  logic [DATAW-1:0]  req_meta,
    output logic              req_ready,
    output logic              mem_req_valid,
    output logic [ADDRW-1:0]  mem_req_addr,
    output logic [TAGW-1:0]   mem_req_tag,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [TAGW-1:0]   mem_rsp_tag,
    input  logic [RDATAW-1:0] mem_rsp_data,
    output logic              mem_rsp_ready,
    output logic              rsp_valid,
    output logic [DATAW-1:0]  rsp_meta,
    output logic [RDATAW-1:0] rsp_data,
    input  logic              rsp_ready,
    output logic [TAGW:0]     pending_count,
    output logic              idle,
    output logic              tag_err
);

    logic [SIZE-1:0]   freeMask_q, freeMask_d;
    logic [DATAW-1:0]  metaTable_q [SIZE];
    logic              memReqValid_q, memReqValid_d;
    logic [ADDRW-1:0]  memReqAddr_q, memReqAddr_d;
    logic [TAGW-1:0]   memReqTag_q, memReqTag_d;
    logic              rspValid_q, rspValid_d;
    logic [DATAW-1:0]  rspMeta_q, rspMeta_d;
    logic [RDATAW-1:0] rspData_q, rspData_d;
    logic [TAGW:0]     pending_q, pending_d;

    logic              reqAccept;
    logic              rspAccept;
    logic              rspRelease;
    logic [TAGW-1:0]   allocTag;

    // Descending scan so the lowest free index is the last one written.
    always_comb begin
        allocTag = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (freeMask_q[i]) begin
                allocTag = TAGW'(i);
            end
        end
    end

    assign req_ready     = (|freeMask_q) & (~memReqValid_q | mem_req_ready);
    assign reqAccept     = req_valid & req_ready;
    assign mem_rsp_ready = ~rspValid_q | rsp_ready;
    assign rspAccept     = mem_rsp_valid & mem_rsp_ready;
    assign rspRelease    = rspAccept & ~freeMask_q[mem_rsp_tag];

    always_comb begin
        freeMask_d    = freeMask_q;
        memReqValid_d = memReqValid_q;
        memReqAddr_d  = memReqAddr_q;
        memReqTag_d   = memReqTag_q;
        rspValid_d    = rspValid_q;
        rspMeta_d     = rspMeta_q;
        rspData_d     = rspData_q;
        pending_d     = pending_q;

        if (reqAccept) begin
            freeMask_d[allocTag] = 1'b0;
            memReqValid_d        = 1'b1;
            memReqAddr_d         = req_addr;
            memReqTag_d          = allocTag;
        end else if (mem_req_ready) begin
            memReqValid_d = 1'b0;
        end

        // A response to an unallocated tag is still forwarded but never touches the pool.
        if (rspAccept) begin
            rspValid_d = 1'b1;
            rspMeta_d  = metaTable_q[mem_rsp_tag];
            rspData_d  = mem_rsp_data;
            if (rspRelease) begin
                freeMask_d[mem_rsp_tag] = 1'b1;
            end
        end else if (rsp_ready) begin
            rspValid_d = 1'b0;
        end

        if (reqAccept && !rspRelease) begin
            pending_d = pending_q + (TAGW+1)'(1);
        end else if (!reqAccept && rspRelease) begin
            pending_d = pending_q - (TAGW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            freeMask_q    <= '1;
            memReqValid_q <= 1'b0;
            memReqAddr_q  <= '0;
            memReqTag_q   <= '0;
            rspValid_q    <= 1'b0;
            rspMeta_q     <= '0;
            rspData_q     <= '0;
            pending_q     <= '0;
        end else begin
            freeMask_q    <= freeMask_d;
            memReqValid_q <= memReqValid_d;
            memReqAddr_q  <= memReqAddr_d;
            memReqTag_q   <= memReqTag_d;
            rspValid_q    <= rspValid_d;
            rspMeta_q     <= rspMeta_d;
            rspData_q     <= rspData_d;
            pending_q     <= pending_d;
        end
    end

    // Contents are meaningful only while a tag is allocated, so the table carries no reset.
    always_ff @(posedge clk) begin
        if (reqAccept) begin
            metaTable_q[allocTag] <= req_meta;
        end
    end

`ifdef RV_TAGGER_CHECK_EN
    logic tagErr_q;
    logic rspUnalloc;

    assign rspUnalloc = rspAccept & freeMask_q[mem_rsp_tag];

    always_ff @(posedge clk) begin
        if (reset) begin
            tagErr_q <= 1'b0;
        end else if (rspUnalloc) begin
            tagErr_q <= 1'b1;
        end
    end

    assign tag_err = tagErr_q;
`else
    assign tag_err = 1'b0;
`endif

    assign mem_req_valid = memReqValid_q;
    assign mem_req_addr  = memReqAddr_q;
    assign mem_req_tag   = memReqTag_q;
    assign rsp_valid     = rspValid_q;
    assign rsp_meta      = rspMeta_q;
    assign rsp_data      = rspData_q;
    assign pending_count = pending_q;
    assign idle          = (pending_q == '0) & ~memReqValid_q & ~rspValid_q;

endmodule

// File: tb/tb_rv_mem_req_tagger.sv
// Self-checking bench for rv_mem_req_tagger: directed scenarios plus a randomized run
// against a tag-pool reference model.
module tb_rv_mem_req_tagger;

    localparam int DATAW  = 8;
    localparam int ADDRW  = 32;
    localparam int RDATAW = 32;
    localparam int SIZE   = 4;
    localparam int TAGW   = 2;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic [ADDRW-1:0]  req_addr;
    logic [DATAW-1:0]  req_meta;
    logic              req_ready;
    logic              mem_req_valid;
    logic [ADDRW-1:0]  mem_req_addr;
    logic [TAGW-1:0]   mem_req_tag;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [TAGW-1:0]   mem_rsp_tag;
    logic [RDATAW-1:0] mem_rsp_data;
    logic              mem_rsp_ready;
    logic              rsp_valid;
    logic [DATAW-1:0]  rsp_meta;
    logic [RDATAW-1:0] rsp_data;
    logic              rsp_ready;
    logic [TAGW:0]     pending_count;
    logic              idle;
    logic              tag_err;

    int total = 0;
    int bad   = 0;

    rv_mem_req_tagger #(
        .DATAW(DATAW), .ADDRW(ADDRW), .RDATAW(RDATAW), .SIZE(SIZE), .TAGW(TAGW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_meta(req_meta), .req_ready(req_ready),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_tag(mem_rsp_tag), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_ready(mem_rsp_ready),
        .rsp_valid(rsp_valid), .rsp_meta(rsp_meta), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .pending_count(pending_count), .idle(idle), .tag_err(tag_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_addr      = '0;
        req_meta      = '0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_tag   = '0;
        mem_rsp_data  = '0;
        rsp_ready     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_req_valid got=%0h exp=0", mem_req_valid); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid got=%0h exp=0", rsp_valid); end
        total++; if (pending_count !== 3'd0) begin bad++; $display("[TB] FAIL reset_pending got=%0d exp=0", pending_count); end
        total++; if (idle !== 1'b1) begin bad++; $display("[TB] FAIL reset_idle got=%0h exp=1", idle); end
        total++; if (tag_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_tag_err got=%0h exp=0", tag_err); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_req_ready got=%0h exp=1", req_ready); end
        total++; if (mem_rsp_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_mem_rsp_ready got=%0h exp=1", mem_rsp_ready); end
        total++; if (mem_req_addr !== 32'h0 || mem_req_tag !== 2'd0) begin bad++; $display("[TB] FAIL reset_mem_req_data got=%0h/%0d exp=0/0", mem_req_addr, mem_req_tag); end
        total++; if (rsp_meta !== 8'h0 || rsp_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_rsp_data got=%0h/%0h exp=0/0", rsp_meta, rsp_data); end
    endtask

    task automatic test_fill();
        doReset();
        for (int i = 0; i < SIZE; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'h1000 + i;
            req_meta  = 8'hA0 + 8'(i);
            #1;
            total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL fill_req_ready[%0d] got=%0h exp=1", i, req_ready); end
            tick();
            total++; if (mem_req_valid !== 1'b1 || mem_req_tag !== TAGW'(i) || mem_req_addr !== 32'h1000 + i)
                begin bad++; $display("[TB] FAIL fill_issue[%0d] got=v%0h t%0d a%0h exp=v1 t%0d a%0h", i, mem_req_valid, mem_req_tag, mem_req_addr, i, 32'h1000 + i); end
        end
        req_meta = 8'hA4;
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL fill_full_req_ready got=%0h exp=0", req_ready); end
        total++; if (pending_count !== 3'd4) begin bad++; $display("[TB] FAIL fill_pending got=%0d exp=4", pending_count); end
        tick();
        total++; if (mem_req_valid !== 1'b0 || pending_count !== 3'd4) begin bad++; $display("[TB] FAIL fill_no_accept got=v%0h p%0d exp=v0 p4", mem_req_valid, pending_count); end
        req_valid = 1'b0;
    endtask

    // Follows test_fill with the pool full.
    task automatic test_release_realloc();
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = 2'd2;
        mem_rsp_data  = 32'hD2;
        req_valid     = 1'b1;
        req_addr      = 32'h2222;
        req_meta      = 8'hB2;
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL release_same_cycle_ready got=%0h exp=0", req_ready); end
        tick();
        mem_rsp_valid = 1'b0;
        total++; if (rsp_valid !== 1'b1 || rsp_meta !== 8'hA2 || rsp_data !== 32'hD2)
            begin bad++; $display("[TB] FAIL release_rsp got=v%0h m%0h d%0h exp=v1 mA2 dD2", rsp_valid, rsp_meta, rsp_data); end
        total++; if (pending_count !== 3'd3 || mem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL release_pending got=p%0d v%0h exp=p3 v0", pending_count, mem_req_valid); end
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL realloc_ready got=%0h exp=1", req_ready); end
        tick();
        req_valid = 1'b0;
        total++; if (mem_req_valid !== 1'b1 || mem_req_tag !== 2'd2 || mem_req_addr !== 32'h2222)
            begin bad++; $display("[TB] FAIL realloc_tag got=v%0h t%0d a%0h exp=v1 t2 a2222", mem_req_valid, mem_req_tag, mem_req_addr); end
        total++; if (pending_count !== 3'd4) begin bad++; $display("[TB] FAIL realloc_pending got=%0d exp=4", pending_count); end
    endtask

    task automatic test_out_of_order();
        int order [4] = '{3, 0, 2, 1};
        doReset();
        for (int i = 0; i < SIZE; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'h4000 + i;
            req_meta  = 8'hA0 + 8'(i);
            tick();
        end
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_tag   = TAGW'(order[k]);
            mem_rsp_data  = 32'hD000_0000 + order[k];
            tick();
            total++; if (rsp_valid !== 1'b1 || rsp_meta !== 8'hA0 + 8'(order[k]) || rsp_data !== 32'hD000_0000 + order[k])
                begin bad++; $display("[TB] FAIL ooo_rsp[%0d] got=v%0h m%0h d%0h exp=v1 m%0h d%0h", k, rsp_valid, rsp_meta, rsp_data, 8'hA0 + 8'(order[k]), 32'hD000_0000 + order[k]); end
        end
        mem_rsp_valid = 1'b0;
        tick();
        total++; if (pending_count !== 3'd0 || rsp_valid !== 1'b0 || idle !== 1'b1)
            begin bad++; $display("[TB] FAIL ooo_drained got=p%0d v%0h i%0h exp=p0 v0 i1", pending_count, rsp_valid, idle); end
    endtask

    task automatic test_backpressure();
        doReset();
        mem_req_ready = 1'b0;
        req_valid     = 1'b1;
        req_addr      = 32'h55;
        req_meta      = 8'h11;
        tick();
        req_addr = 32'h66;
        req_meta = 8'h22;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (req_ready !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h55 || mem_req_tag !== 2'd0)
                begin bad++; $display("[TB] FAIL stall_hold[%0d] got=r%0h v%0h a%0h t%0d exp=r0 v1 a55 t0", c, req_ready, mem_req_valid, mem_req_addr, mem_req_tag); end
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h66 || mem_req_tag !== 2'd1)
            begin bad++; $display("[TB] FAIL stall_release got=v%0h a%0h t%0d exp=v1 a66 t1", mem_req_valid, mem_req_addr, mem_req_tag); end
        tick();
        rsp_ready     = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = 2'd0;
        mem_rsp_data  = 32'h77;
        tick();
        mem_rsp_tag  = 2'd1;
        mem_rsp_data = 32'h88;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++; if (mem_rsp_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_meta !== 8'h11 || rsp_data !== 32'h77 || pending_count !== 3'd1)
                begin bad++; $display("[TB] FAIL rsp_hold[%0d] got=r%0h v%0h m%0h d%0h p%0d exp=r0 v1 m11 d77 p1", c, mem_rsp_ready, rsp_valid, rsp_meta, rsp_data, pending_count); end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        total++; if (rsp_valid !== 1'b1 || rsp_meta !== 8'h22 || rsp_data !== 32'h88 || pending_count !== 3'd0)
            begin bad++; $display("[TB] FAIL rsp_release got=v%0h m%0h d%0h p%0d exp=v1 m22 d88 p0", rsp_valid, rsp_meta, rsp_data, pending_count); end
    endtask

    task automatic test_simultaneous();
        doReset();
        req_valid = 1'b1;
        req_meta  = 8'h30;
        tick();
        total++; if (pending_count !== 3'd1 || mem_req_tag !== 2'd0) begin bad++; $display("[TB] FAIL simul_first got=p%0d t%0d exp=p1 t0", pending_count, mem_req_tag); end
        req_meta      = 8'h31;
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = 2'd0;
        mem_rsp_data  = 32'h99;
        tick();
        mem_rsp_valid = 1'b0;
        total++; if (mem_req_tag !== 2'd1 || pending_count !== 3'd1 || rsp_meta !== 8'h30 || rsp_data !== 32'h99)
            begin bad++; $display("[TB] FAIL simul_both got=t%0d p%0d m%0h d%0h exp=t1 p1 m30 d99", mem_req_tag, pending_count, rsp_meta, rsp_data); end
        req_meta = 8'h32;
        tick();
        req_valid = 1'b0;
        total++; if (mem_req_tag !== 2'd0 || pending_count !== 3'd2) begin bad++; $display("[TB] FAIL simul_realloc got=t%0d p%0d exp=t0 p2", mem_req_tag, pending_count); end
    endtask

    task automatic test_tag_err();
        logic expErr;
`ifdef RV_TAGGER_CHECK_EN
        expErr = 1'b1;
`else
        expErr = 1'b0;
`endif
        doReset();
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = 2'd3;
        mem_rsp_data  = 32'h5;
        tick();
        mem_rsp_valid = 1'b0;
        total++; if (tag_err !== expErr || rsp_valid !== 1'b1 || rsp_data !== 32'h5 || pending_count !== 3'd0)
            begin bad++; $display("[TB] FAIL tag_err_set got=e%0h v%0h d%0h p%0d exp=e%0h v1 d5 p0", tag_err, rsp_valid, rsp_data, pending_count, expErr); end
        tick();
        tick();
        total++; if (tag_err !== expErr || pending_count !== 3'd0) begin bad++; $display("[TB] FAIL tag_err_sticky got=e%0h p%0d exp=e%0h p0", tag_err, pending_count, expErr); end
        req_valid = 1'b1;
        req_meta  = 8'h44;
        tick();
        req_valid = 1'b0;
        total++; if (mem_req_tag !== 2'd0 || pending_count !== 3'd1) begin bad++; $display("[TB] FAIL tag_err_pool got=t%0d p%0d exp=t0 p1", mem_req_tag, pending_count); end
        doReset();
        total++; if (tag_err !== 1'b0) begin bad++; $display("[TB] FAIL tag_err_reset got=%0h exp=0", tag_err); end
    endtask

    // Reference model: which tags are held and by what metadata, plus the two output stages.
    task automatic test_random();
        bit              held [SIZE];
        logic [DATAW-1:0] heldMeta [SIZE];
        bit               mVal, rVal;
        logic [ADDRW-1:0] mAddr;
        int               mTag;
        logic [DATAW-1:0] rMeta;
        logic [RDATAW-1:0] rData;
        int               busy, lowFree;
        bit               expReqReady, expRspReady;
        int               q [$];
        doReset();
        for (int i = 0; i < SIZE; i++) held[i] = 1'b0;
        mVal = 0; rVal = 0; mAddr = '0; mTag = 0; rMeta = '0; rData = '0;
        for (int n = 0; n < 600; n++) begin
            req_valid     = ($urandom_range(0, 3) != 0);
            req_addr      = $urandom;
            req_meta      = DATAW'($urandom);
            mem_req_ready = ($urandom_range(0, 3) != 0);
            rsp_ready     = ($urandom_range(0, 3) != 0);
            mem_rsp_data  = $urandom;
            q.delete();
            for (int i = 0; i < SIZE; i++) if (held[i]) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_tag   = TAGW'(q[$urandom_range(0, q.size() - 1)]);
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rsp_tag   = TAGW'($urandom_range(0, SIZE - 1));
            end
            #1;
            busy = 0;
            lowFree = -1;
            for (int i = 0; i < SIZE; i++) begin
                if (held[i]) busy++;
                else if (lowFree < 0) lowFree = i;
            end
            expReqReady = (lowFree >= 0) && (!mVal || mem_req_ready);
            expRspReady = !rVal || rsp_ready;
            total++; if (req_ready !== expReqReady) begin bad++; $display("[TB] FAIL rnd_req_ready@%0d got=%0h exp=%0h", n, req_ready, expReqReady); end
            total++; if (mem_rsp_ready !== expRspReady) begin bad++; $display("[TB] FAIL rnd_mem_rsp_ready@%0d got=%0h exp=%0h", n, mem_rsp_ready, expRspReady); end
            total++; if (pending_count !== (TAGW+1)'(busy)) begin bad++; $display("[TB] FAIL rnd_pending@%0d got=%0d exp=%0d", n, pending_count, busy); end
            total++; if (idle !== (busy == 0 && !mVal && !rVal)) begin bad++; $display("[TB] FAIL rnd_idle@%0d got=%0h exp=%0h", n, idle, (busy == 0 && !mVal && !rVal)); end
            total++; if (tag_err !== 1'b0) begin bad++; $display("[TB] FAIL rnd_tag_err@%0d got=%0h exp=0", n, tag_err); end
            total++; if (mem_req_valid !== mVal || (mVal && (mem_req_addr !== mAddr || mem_req_tag !== TAGW'(mTag))))
                begin bad++; $display("[TB] FAIL rnd_mem_req@%0d got=v%0h a%0h t%0d exp=v%0h a%0h t%0d", n, mem_req_valid, mem_req_addr, mem_req_tag, mVal, mAddr, mTag); end
            total++; if (rsp_valid !== rVal || (rVal && (rsp_meta !== rMeta || rsp_data !== rData)))
                begin bad++; $display("[TB] FAIL rnd_rsp@%0d got=v%0h m%0h d%0h exp=v%0h m%0h d%0h", n, rsp_valid, rsp_meta, rsp_data, rVal, rMeta, rData); end
            if (mem_rsp_valid && expRspReady) begin
                rVal  = 1;
                rMeta = heldMeta[mem_rsp_tag];
                rData = mem_rsp_data;
                held[mem_rsp_tag] = 1'b0;
            end else if (rsp_ready) begin
                rVal = 0;
            end
            if (req_valid && expReqReady) begin
                held[lowFree]     = 1'b1;
                heldMeta[lowFree] = req_meta;
                mVal  = 1;
                mAddr = req_addr;
                mTag  = lowFree;
            end else if (mem_req_ready) begin
                mVal = 0;
            end
            tick();
        end
        req_valid     = 1'b0;
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_release_realloc();
        test_out_of_order();
        test_backpressure();
        test_simultaneous();
        test_tag_err();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_mem_req_tagger.md
# rv_mem_req_tagger

Tags outstanding memory requests from a load/store unit and restores per-request metadata on the return path. It accepts one request per cycle, allocates the lowest free tag from a SIZE-entry pool, stores the request's metadata under that tag, and issues the request downstream with the tag attached. Out-of-order responses are matched by tag, joined with their stored metadata, and forwarded upstream, freeing the tag. The block sits between the LSU request path and the memory interface.

## Interface
- DATAW, 8, metadata width stored per request
- ADDRW, 32, memory address width
- RDATAW, 32, response data width
- SIZE, 4, number of tags / outstanding requests (power of two, ≥2)
- TAGW, $clog2(SIZE), tag width

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  upstream request valid
- req_addr  in  ADDRW  request address
- req_meta  in  DATAW  metadata to store
- req_ready  out  1  request accepted when valid&ready
- mem_req_valid  out  1  downstream request valid (registered)
- mem_req_addr  out  ADDRW  downstream address
- mem_req_tag  out  TAGW  allocated tag
- mem_req_ready  in  1  downstream accept
- mem_rsp_valid  in  1  memory response valid
- mem_rsp_tag  in  TAGW  response tag
- mem_rsp_data  in  RDATAW  response data
- mem_rsp_ready  out  1  response accepted when valid&ready
- rsp_valid  out  1  upstream response valid (registered)
- rsp_meta  out  DATAW  metadata restored for the tag
- rsp_data  out  RDATAW  response data
- rsp_ready  in  1  upstream accept
- pending_count  out  TAGW+1  tags currently allocated
- idle  out  1  pending_count==0 and both output stages empty
- tag_err  out  1  sticky: response carried an unallocated tag (see Configuration)

## Operation
- State: free mask (SIZE bits, 1=free), metadata table (SIZE×DATAW), request output register, response output register, pending counter.
- req_ready = (free mask nonzero) & (!mem_req_valid | mem_req_ready). Uses the registered free mask only; a tag released this cycle is not usable this cycle.
- Accept: tag = lowest-index free bit; clear its bit; write req_meta to table[tag]; load mem_req_valid=1, addr, tag. Register holds stable while mem_req_valid & !mem_req_ready.
- mem_req_valid clears on mem_req_ready with no new accept.
- mem_rsp_ready = !rsp_valid | rsp_ready.
- Response accept: rsp_valid=1, rsp_meta=table[mem_rsp_tag], rsp_data=mem_rsp_data; set free bit for mem_rsp_tag. Holds stable while rsp_valid & !rsp_ready.
- Simultaneous accept and release: both applied; different tags guaranteed (accepted tag is free, released tag is allocated). Metadata write and read of different entries same cycle legal.
- pending_count: +1 on accept, −1 on valid release, unchanged when both.
- Responses may return in any order; response for a tag may arrive the cycle after its mem_req handshake.

## Timing
- Reset values: mem_req_valid=0, rsp_valid=0, pending_count=0, idle=1, tag_err=0, req_ready=1, mem_rsp_ready=1, data outputs 0, free mask all ones. Table contents undefined.
- req handshake → mem_req_valid: 1 cycle. mem_rsp handshake → rsp_valid: 1 cycle. Freed tag allocatable from cycle after release.
- Full throughput: one request and one response per cycle when both sides ready.
- Reset mid-operation: all tags freed, output stages dropped; in-flight memory responses after reset are treated as unallocated tags.

## Configuration
- RV_TAGGER_CHECK_EN defined: response with tag whose free bit is set still produces rsp (stale metadata) but sets tag_err sticky until reset; free mask and pending_count unchanged for it.
- Undefined: tag_err tied 0; such response forwarded, release is a no-op on the mask and pending_count not decremented.

## Test plan
- Reset then 4 back-to-back requests, mem_req_ready=1 → tags 0,1,2,3; 5th request sees req_ready=0; pending_count=4.
- Full, respond tag 2 → tag 2 free next cycle; next request gets tag 2, not earlier.
- Requests meta 0xA0..0xA3, responses in order 3,0,2,1 → rsp_meta 0xA3,0xA0,0xA2,0xA1 with matching data.
- mem_req_ready=0 for 3 cycles → mem_req_* stable, req_ready=0; rsp_ready=0 → mem_rsp_ready=0, rsp held.
- Same-cycle accept (gets tag 1) and release tag 0 with pending=1 → pending stays 1, next alloc tag 0.
- With RV_TAGGER_CHECK_EN, response tag 3 while free → tag_err=1 next cycle, remains 1, pending_count unchanged.
